// File: rtl/mc_initiator.sv
// mc_initiator: parallel async-SRAM-style bus initiator with programmable setup/strobe/hold phases.
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   req_valid/req_ready     one request at a time; accepted on req_valid && req_ready
//   req_write/req_add/req_wdata  request kind, address and write data
//   setup/strobe/hold_cycles     phase lengths, latched at accept
//   rsp_valid/rsp_rdata     one-cycle read response pulse; data held until the next read
//   mc_ce/mc_oe/mc_we       active-low bus strobes
//   mc_add/mc_dout/mc_doe   bus address, write data and pad output enable
//   mc_din                  read data from the pad
//   mc_wait                 strobe extension input, present only with MC_INIT_WAIT_EN defined
module mc_initiator #(
  parameter int ADD_WIDTH    = 6,
  parameter int DATA_WIDTH   = 16,
  parameter int TIMING_WIDTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADD_WIDTH-1:0]    req_add,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [TIMING_WIDTH-1:0] setup_cycles,
  input  logic [TIMING_WIDTH-1:0] strobe_cycles,
  input  logic [TIMING_WIDTH-1:0] hold_cycles,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    mc_ce,
  output logic                    mc_oe,
  output logic                    mc_we,
  output logic [ADD_WIDTH-1:0]    mc_add,
  output logic [DATA_WIDTH-1:0]   mc_dout,
  output logic                    mc_doe,
  input  logic [DATA_WIDTH-1:0]   mc_din
`ifdef MC_INIT_WAIT_EN
  ,
  input  logic                    mc_wait
`endif
);
  localparam logic [TIMING_WIDTH-1:0] ONE = TIMING_WIDTH'(1);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  state_t state_q, state_d;
  logic [TIMING_WIDTH-1:0] cnt_q, cnt_d, t_q, t_d, h_q, h_d;
  logic wr_q, wr_d;
  logic req_ready_q, req_ready_d;
  logic rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic mc_ce_q, mc_ce_d, mc_oe_q, mc_oe_d, mc_we_q, mc_we_d, mc_doe_q, mc_doe_d;
  logic [ADD_WIDTH-1:0] mc_add_q, mc_add_d;
  logic [DATA_WIDTH-1:0] mc_dout_q, mc_dout_d;
  logic accept, cnt_done, stall, strobe_end;
  // cnt_q holds the cycles remaining in the current phase minus one
  always_comb begin
    accept = req_valid && req_ready_q;
    cnt_done = cnt_q == '0;
`ifdef MC_INIT_WAIT_EN
    stall = mc_wait;
`else
    stall = 1'b0;
`endif
    strobe_end = state_q == STROBE && cnt_done && !stall;
    state_d = state_q;
    cnt_d = cnt_done ? cnt_q : cnt_q - ONE;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d = SETUP;
        cnt_d = setup_cycles == '0 ? '0 : setup_cycles - ONE;
      end
      SETUP: if (cnt_done) begin
        state_d = STROBE;
        cnt_d = t_q - ONE;
      end
      STROBE: if (strobe_end) begin
        state_d = h_q == '0 ? IDLE : HOLD;
        cnt_d = h_q - ONE;
      end
      HOLD: if (cnt_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    wr_d = accept ? req_write : wr_q;
    t_d = accept ? (strobe_cycles == '0 ? ONE : strobe_cycles) : t_q;
    h_d = accept ? hold_cycles : h_q;
    mc_add_d = accept ? req_add : mc_add_q;
    mc_dout_d = accept && req_write ? req_wdata : mc_dout_q;
    // Outputs are decoded from the next state so they change on the same edge as the state
    mc_ce_d = state_d == IDLE;
    mc_oe_d = !(state_d == STROBE && !wr_d);
    mc_we_d = !(state_d == STROBE && wr_d);
    mc_doe_d = state_d != IDLE && wr_d;
    req_ready_d = state_d == IDLE;
    rsp_valid_d = strobe_end && !wr_q;
    rsp_rdata_d = rsp_valid_d ? mc_din : rsp_rdata_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      t_q <= ONE;
      h_q <= '0;
      wr_q <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      mc_ce_q <= 1'b1;
      mc_oe_q <= 1'b1;
      mc_we_q <= 1'b1;
      mc_doe_q <= 1'b0;
      mc_add_q <= '0;
      mc_dout_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      t_q <= t_d;
      h_q <= h_d;
      wr_q <= wr_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      mc_ce_q <= mc_ce_d;
      mc_oe_q <= mc_oe_d;
      mc_we_q <= mc_we_d;
      mc_doe_q <= mc_doe_d;
      mc_add_q <= mc_add_d;
      mc_dout_q <= mc_dout_d;
    end
  end
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mc_ce = mc_ce_q;
  assign mc_oe = mc_oe_q;
  assign mc_we = mc_we_q;
  assign mc_doe = mc_doe_q;
  assign mc_add = mc_add_q;
  assign mc_dout = mc_dout_q;
endmodule

// File: tb/tb_mc_initiator.sv
// tb_mc_initiator: randomized self-checking bench for mc_initiator against a cycle-position model
module tb_mc_initiator;
  logic clock = 1'b0, reset = 1'b1;
  logic req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [5:0] req_add = '0;
  logic [15:0] req_wdata = '0;
  logic [3:0] setup_cycles = '0, strobe_cycles = '0, hold_cycles = '0;
  logic rsp_valid;
  logic [15:0] rsp_rdata;
  logic mc_ce, mc_oe, mc_we, mc_doe;
  logic [5:0] mc_add;
  logic [15:0] mc_dout, mc_din = '0;
  logic mc_wait = 1'b0;
  int checks = 0, errors = 0;
  logic [15:0] last_rd = '0;

  mc_initiator dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_add(req_add), .req_wdata(req_wdata),
    .setup_cycles(setup_cycles), .strobe_cycles(strobe_cycles), .hold_cycles(hold_cycles),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .mc_ce(mc_ce), .mc_oe(mc_oe), .mc_we(mc_we),
    .mc_add(mc_add), .mc_dout(mc_dout), .mc_doe(mc_doe), .mc_din(mc_din)
`ifdef MC_INIT_WAIT_EN
    , .mc_wait(mc_wait)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One transaction from IDLE back to IDLE. Cycle k is the cycle after edge E+k, E being the accept edge.
  // Phase lengths: S=max(s,1); T=max(t,1), stretched to w+1 when mc_wait is high w strobe cycles; H=h.
  task automatic txn(input bit wr, input logic [5:0] a, input logic [15:0] wd,
                     input int s, input int t, input int h, input int w,
                     input bit rnd, input logic [15:0] din);
    int es, et, te, len;
    logic [15:0] cap;
    es = s < 1 ? 1 : s;
    et = t < 1 ? 1 : t;
`ifdef MC_INIT_WAIT_EN
    te = w >= et ? w + 1 : et;
`else
    te = et;
`endif
    len = es + te + h;
    cap = last_rd;
    req_valid = 1'b1;
    req_write = wr;
    req_add = a;
    req_wdata = wd;
    setup_cycles = 4'(s);
    strobe_cycles = 4'(t);
    hold_cycles = 4'(h);
    mc_din = rnd ? 16'($urandom) : din;
    mc_wait = 1'b0;
    tick();
    for (int k = 0; k <= len; k++) begin
      chk("mc_ce", mc_ce, k >= len);
      chk("mc_oe", mc_oe, !(!wr && k >= es && k < es + te));
      chk("mc_we", mc_we, !(wr && k >= es && k < es + te));
      chk("mc_doe", mc_doe, wr && k < len);
      chk("req_ready", req_ready, k >= len);
      chk("rsp_valid", rsp_valid, !wr && k == es + te);
      chk("rsp_rdata", rsp_rdata, (!wr && k >= es + te) ? cap : last_rd);
      if (k < len) chk("mc_add", mc_add, a);
      if (k < len && wr) chk("mc_dout", mc_dout, wd);
      if (k == len) break;
      mc_din = rnd ? 16'($urandom) : din;
      if (k == es + te - 1) cap = mc_din;
      mc_wait = k >= es && k < es + w;
      // request bus and phase inputs wander while busy; nothing may be re-latched
      req_write = 1'($urandom);
      req_add = 6'($urandom);
      req_wdata = 16'($urandom);
      setup_cycles = 4'($urandom);
      strobe_cycles = 4'($urandom);
      hold_cycles = 4'($urandom);
      tick();
    end
    req_valid = 1'b0;
    mc_wait = 1'b0;
    if (!wr) last_rd = cap;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_ce", mc_ce, 1'b1);
    chk("rst_oe", mc_oe, 1'b1);
    chk("rst_we", mc_we, 1'b1);
    chk("rst_doe", mc_doe, 1'b0);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rdata", rsp_rdata, 16'h0);
    chk("rst_add", mc_add, 6'h0);
    chk("rst_dout", mc_dout, 16'h0);
    reset = 1'b0;
    tick();
    chk("idle_ce", mc_ce, 1'b1);
    chk("idle_ready", req_ready, 1'b1);
    // directed scenarios
    txn(1'b1, 6'h19, 16'hBEEF, 1, 2, 1, 0, 1'b1, 16'h0);
    tick();
    txn(1'b0, 6'h00, 16'h0, 0, 0, 0, 0, 1'b0, 16'h1234);
    chk("rd_0x1234", last_rd, 16'h1234);
    tick();
    // back-to-back read then write with one IDLE cycle in between
    txn(1'b0, 6'h2C, 16'h0, 2, 1, 2, 0, 1'b1, 16'h0);
    txn(1'b1, 6'h13, 16'h5A5A, 1, 1, 0, 0, 1'b1, 16'h0);
    txn(1'b0, 6'h3F, 16'h0, 3, 2, 0, 0, 1'b1, 16'h0);
    // strobe latched as 2 even though the input moves on after accept
    txn(1'b0, 6'h07, 16'h0, 1, 2, 1, 0, 1'b1, 16'h0);
`ifdef MC_INIT_WAIT_EN
    txn(1'b0, 6'h2A, 16'h0, 1, 1, 0, 3, 1'b0, 16'hA5A5);
    chk("wait_rd", last_rd, 16'hA5A5);
`endif
    // reset during STROBE of a read
    req_valid = 1'b1;
    req_write = 1'b0;
    req_add = 6'h21;
    setup_cycles = 4'd1;
    strobe_cycles = 4'd3;
    hold_cycles = 4'd0;
    tick();
    req_valid = 1'b0;
    tick();
    chk("mid_oe", mc_oe, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    last_rd = '0;
    for (int i = 0; i < 4; i++) begin
      chk("rr_ce", mc_ce, 1'b1);
      chk("rr_oe", mc_oe, 1'b1);
      chk("rr_we", mc_we, 1'b1);
      chk("rr_doe", mc_doe, 1'b0);
      chk("rr_ready", req_ready, 1'b1);
      chk("rr_rsp_valid", rsp_valid, 1'b0);
      chk("rr_rdata", rsp_rdata, 16'h0);
      tick();
    end
    // randomized transactions, back-to-back or with idle gaps
    for (int n = 0; n < 30; n++) begin
      txn(1'($urandom), 6'($urandom), 16'($urandom), $urandom_range(0, 4), $urandom_range(0, 4),
          $urandom_range(0, 3), $urandom_range(0, 4), 1'b1, 16'h0);
      if ($urandom_range(0, 2) == 0) tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mc_initiator.md
# mc_initiator

Parallel async-SRAM-style bus initiator. Drives chip-enable, output-enable, write-enable, address and data with programmable setup/strobe/hold phases, the opposite end of the FPGA's memory-controller responder. Used to drive external parallel peripherals and as an in-fabric loopback stimulus for the responder. Accepts one request at a time over a valid/ready port and returns read data as a one-cycle response pulse.

## Interface

- ADD_WIDTH, 6, address bus width
- DATA_WIDTH, 16, data bus width
- TIMING_WIDTH, 4, width of each phase-length input
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; accept on req_valid && req_ready
- req_write  in  1  1 = write, 0 = read
- req_add  in  ADD_WIDTH  target address
- req_wdata  in  DATA_WIDTH  write data
- setup_cycles / strobe_cycles / hold_cycles  in  TIMING_WIDTH each  phase lengths, latched at accept
- rsp_valid  out  1  one-cycle pulse, read data valid
- rsp_rdata  out  DATA_WIDTH  captured read data, held until next read
- mc_ce, mc_oe, mc_we  out  1 each  active-low strobes
- mc_add  out  ADD_WIDTH  address
- mc_dout  out  DATA_WIDTH  write data to pad
- mc_doe  out  1  pad output enable for mc_dout
- mc_din  in  DATA_WIDTH  read data from pad
- mc_wait  in  1  present only with MC_INIT_WAIT_EN

## Operation

- States: IDLE, SETUP, STROBE, HOLD. All outputs registered.
- Effective lengths: S = max(setup_cycles,1), T = max(strobe_cycles,1), H = hold_cycles (0 skips HOLD).
- IDLE: mc_ce=mc_oe=mc_we=1, mc_doe=0, req_ready=1. Accept latches write flag, address, wdata, S/T/H; goes to SETUP.
- SETUP (S cycles): mc_ce=0, mc_add=latched address; write: mc_doe=1, mc_dout=wdata. Strobes high.
- STROBE (T cycles): read asserts mc_oe=0; write asserts mc_we=0. Address/data/ce unchanged.
- Read capture: mc_din registered into rsp_rdata on the edge that ends STROBE; rsp_valid=1 the following cycle only.
- HOLD (H cycles): strobes high; mc_ce=0, address, write data and mc_doe held.
- Leaving last phase → IDLE: mc_ce=1, mc_doe=0 at same edge.
- mc_doe never 1 during a read transaction.
- Phase inputs changing mid-transaction have no effect.
- Write produces no response.

## Timing

- Reset values: state IDLE, req_ready=1, mc_ce=mc_oe=mc_we=1, mc_doe=0, mc_add=0, mc_dout=0, rsp_valid=0, rsp_rdata=0.
- Accept at edge E: SETUP from E; STROBE from E+S; rsp_valid high in cycle after edge E+S+T; IDLE from E+S+T+H.
- Minimum transaction 3 cycles including IDLE; at least one IDLE cycle (mc_ce=1) between consecutive transactions, giving bus turnaround after reads.
- reset mid-transaction: next edge forces reset values; no rsp_valid emitted; request lost.

## Configuration

- MC_INIT_WAIT_EN defined: mc_wait port exists; after T strobe cycles, STROBE extends while mc_wait=1; read capture on the edge ending the extended strobe. No timeout.
- Undefined: no mc_wait port; STROBE exactly T cycles.

## Test plan

- Write addr 0x19 data 0xBEEF, S/T/H=1/2/1 → mc_ce low 4 cycles, mc_we low cycles 2–3, mc_doe=1 for those 4 cycles, mc_dout=0xBEEF, no rsp_valid.
- Read addr 0x00, S/T/H=0/0/0, mc_din=0x1234 → mc_oe low 1 cycle, rsp_valid at edge E+2, rsp_rdata=0x1234, mc_doe stays 0.
- Back-to-back read then write, req_valid held → mc_ce high exactly 1 cycle between them; req_ready low throughout each transaction.
- Change strobe_cycles 2→7 during SETUP → strobe still 2 cycles.
- reset asserted mid-STROBE of a read → next edge all strobes high, mc_doe=0, rsp_valid never pulses, req_ready=1.
- MC_INIT_WAIT_EN, T=1, mc_wait high 3 cycles → mc_oe low 4 cycles; data sampled at end of 4th; without macro, mc_oe low 1 cycle.
